sha256_host: RTL and testbench
==============================

Name: sha256_host

Overview:
- Bus-master counterpart to the byte-addressed SHA-256 core.
- Accepts a message byte stream (1..55 bytes) and applies FIPS 180-4 single-block padding.
- Writes the 64-byte block into the core's word memory, starts the core, and waits for its completion pulse.
- Reads the 32-byte digest back and emits it as a byte stream with backpressure.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the run is declared failed.
- MAX_MSG_BYTES, 55: largest message that fits one padded block. Fixed; not to be overridden.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active high
- i_msg_data  in  8  message byte
- i_msg_valid  in  1  message byte valid
- i_msg_last  in  1  final byte of message
- o_msg_ready  out  1  message byte accepted when valid&ready
- o_dig_data  out  8  digest byte, MSB of H0 first
- o_dig_valid  out  1  digest byte valid
- o_dig_last  out  1  with 32nd digest byte
- i_dig_ready  in  1  sink accepts digest byte
- o_busy  out  1  high in every state except IDLE
- o_err  out  1  sticky; cleared on next accepted first message byte
- o_core_rst_n  out  1  core reset, active low
- o_core_addr  out  7  core register address
- o_core_data8  out  8  core write data
- o_core_we  out  1  core write strobe
- i_core_data  in  8  core combinational read data for o_core_addr
- i_core_irq  in  1  core completion pulse, 1 cycle

Behaviour:
- Reset values (i_rst, sync): state IDLE, all outputs 0 including o_core_rst_n=0, counters 0. Reset mid-operation aborts immediately; no further core writes occur.
- Addressing:
  - Block byte k (0 = first transmitted) goes to address 63-k.
  - Status register is address 65; start is written as 0x01.
  - Digest byte j (0..31) is read from address 101-j.
- FSM states and transitions:
  - IDLE: o_core_rst_n=1, o_msg_ready=0. On i_msg_valid -> CRST.
  - CRST: o_core_rst_n=0 for exactly 1 cycle, which clears carried-over chaining state in the core. -> LOAD.
  - LOAD: o_msg_ready=1. Each handshake writes the byte: o_core_we=1, addr=63-cnt, data=i_msg_data, same cycle; cnt++. Core writes happen only on handshake cycles.
    - Handshake with last=1 -> PAD, with n=cnt+1.
    - Handshake with cnt==55 and last=0 -> set o_err, go to DRAIN.
  - DRAIN: o_msg_ready=1, discard bytes, no core writes. On last -> IDLE.
  - PAD: one write per cycle, k = n..63:
    - k==n: 0x80.
    - n<k<62: 0x00.
    - k==62: bitlen[15:8].
    - k==63: bitlen[7:0].
    - bitlen = 8*n (max 440, 16-bit).
    - After k==63 -> START.
  - START: one write, addr 65, data 0x01. -> WAIT; timer=0.
  - WAIT: no writes; timer++.
    - i_core_irq=1 -> READ, j=0.
    - timer==TIMEOUT_CYCLES -> set o_err, go to IDLE; no digest is emitted.
  - READ:
    - o_core_addr=101-j, o_core_we=0. i_core_data is registered into o_dig_data; o_dig_valid rises the next cycle.
    - o_dig_data/valid/last are held stable until i_dig_ready; then j++ and the next address is presented.
    - One byte per 2 cycles is acceptable; a fully pipelined read is permitted if ordering is preserved.
    - After handshake of j==31 (o_dig_last=1) -> IDLE.
- i_msg_last on the first byte gives n=1. There are no zero-length messages.
- i_core_irq outside WAIT is ignored.
- i_msg_valid in states other than LOAD/DRAIN/IDLE is ignored; o_msg_ready=0 there.
- o_err is never set by backpressure.
- Latency, message streamed back-to-back:
  - IDLE to START write = 1 + 64 + 1 cycles, independent of n.
  - START to first o_dig_valid = core run time + 2 cycles.

Test Plan:
- Message "abc" (0x61,0x62,0x63, last on 3rd), i_dig_ready=1:
  - Core writes: 63=61, 62=62, 61=63, 60=80, 59..2=00, 1=00, 0=18, then 65=01.
  - Digest bytes: ba 78 16 bf 8f 01 cf ea 41 41 40 de 5d ae 22 23 b0 03 61 a3 96 17 7a 9c b4 10 ff 61 f2 00 15 ad.
  - o_dig_last on byte 31; o_err=0.
- Two back-to-back "abc" runs -> identical digests. Confirms the CRST pulse precedes each load.
- 55-byte message of 0x00:
  - Writes 8=80, 1=01, 0=B8.
  - Digest 02779466cdec163811d078815c633f21901413081449002f24aa3e80f0b88ef7.
- 56-byte message -> o_err=1 after 56th handshake. Remaining bytes are drained until last, with no write to addr 65. The next "abc" clears o_err and produces the correct digest.
- Stub core with i_core_irq tied 0 -> o_err=1 exactly TIMEOUT_CYCLES cycles after the START write; return to IDLE with o_busy=0.
- i_dig_ready toggling 1-of-3 cycles during "abc" -> o_dig_data stable while stalled; same 32 bytes in order.
- i_rst asserted during LOAD at cnt=10 -> next cycle all outputs 0. A fresh "abc" afterwards yields the correct digest.

Source files
------------

// File: rtl/sha256_host.sv
// Host-side sequencer for the byte-addressed SHA-256 core: pads one message block,
// loads it, starts the core, waits for completion and streams the digest out.
module sha256_host #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_MSG_BYTES  = 55
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_msg_data,
  input  logic       i_msg_valid,
  input  logic       i_msg_last,
  output logic       o_msg_ready,
  output logic [7:0] o_dig_data,
  output logic       o_dig_valid,
  output logic       o_dig_last,
  input  logic       i_dig_ready,
  output logic       o_busy,
  output logic       o_err,
  output logic       o_core_rst_n,
  output logic [6:0] o_core_addr,
  output logic [7:0] o_core_data8,
  output logic       o_core_we,
  input  logic [7:0] i_core_data,
  input  logic       i_core_irq
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // cnt is the byte index in LOAD/PAD and the digest byte index in READ
  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOAD, S_DRAIN, S_PAD, S_START, S_WAIT, S_READ
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    cnt, cnt_nxt;
  logic [5:0]    nbytes, nbytes_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          err_nxt;
  logic          dig_valid_nxt, dig_last_nxt;
  logic [7:0]    dig_data_nxt;
  logic          core_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      nbytes      <= '0;
      timer       <= '0;
      o_err       <= 1'b0;
      o_dig_valid <= 1'b0;
      o_dig_data  <= '0;
      o_dig_last  <= 1'b0;
      core_en     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      nbytes      <= nbytes_nxt;
      timer       <= timer_nxt;
      o_err       <= err_nxt;
      o_dig_valid <= dig_valid_nxt;
      o_dig_data  <= dig_data_nxt;
      o_dig_last  <= dig_last_nxt;
      core_en     <= 1'b1;
    end
  end

  // core_en keeps the core held in reset for as long as the host itself is in reset
  assign o_core_rst_n = core_en && (state != S_CRST);
  assign o_busy       = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    nbytes_nxt    = nbytes;
    timer_nxt     = timer;
    err_nxt       = o_err;
    dig_valid_nxt = o_dig_valid;
    dig_data_nxt  = o_dig_data;
    dig_last_nxt  = o_dig_last;
    o_msg_ready   = 1'b0;
    o_core_we     = 1'b0;
    o_core_addr   = '0;
    o_core_data8  = '0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (i_msg_valid) state_nxt = S_CRST;
      end

      S_CRST: state_nxt = S_LOAD;

      S_LOAD: begin
        o_msg_ready = 1'b1;
        if (i_msg_valid) begin
          o_core_we    = 1'b1;
          o_core_addr  = 7'd63 - {1'b0, cnt};
          o_core_data8 = i_msg_data;
          cnt_nxt      = cnt + 6'd1;
          if (cnt == 6'd0) err_nxt = 1'b0;
          if (cnt == 6'(MAX_MSG_BYTES)) begin
            err_nxt   = 1'b1;
            state_nxt = i_msg_last ? S_IDLE : S_DRAIN;
          end else if (i_msg_last) begin
            nbytes_nxt = cnt + 6'd1;
            state_nxt  = S_PAD;
          end
        end
      end

      S_DRAIN: begin
        o_msg_ready = 1'b1;
        if (i_msg_valid && i_msg_last) state_nxt = S_IDLE;
      end

      S_PAD: begin
        o_core_we   = 1'b1;
        o_core_addr = 7'd63 - {1'b0, cnt};
        // bit length 8*n never exceeds 440, so only two length bytes are non-zero
        if (cnt == nbytes)      o_core_data8 = 8'h80;
        else if (cnt == 6'd62)  o_core_data8 = {7'd0, nbytes[5]};
        else if (cnt == 6'd63)  o_core_data8 = {nbytes[4:0], 3'd0};
        cnt_nxt = cnt + 6'd1;
        if (cnt == 6'd63) state_nxt = S_START;
      end

      S_START: begin
        o_core_we    = 1'b1;
        o_core_addr  = 7'd65;
        o_core_data8 = 8'h01;
        timer_nxt    = '0;
        state_nxt    = S_WAIT;
      end

      S_WAIT: begin
        timer_nxt = timer + TW'(1);
        if (i_core_irq) begin
          cnt_nxt   = '0;
          state_nxt = S_READ;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_READ: begin
        o_core_addr = 7'd101 - {2'b00, cnt[4:0]};
        if (!o_dig_valid) begin
          dig_valid_nxt = 1'b1;
          dig_data_nxt  = i_core_data;
          dig_last_nxt  = (cnt == 6'd31);
        end else if (i_dig_ready) begin
          dig_valid_nxt = 1'b0;
          dig_last_nxt  = 1'b0;
          cnt_nxt       = cnt + 6'd1;
          if (o_dig_last) state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_host.sv
// Bench for sha256_host: a behavioural SHA-256 core (with chaining unless reset)
// answers the host, and every digest is compared with an independent padding+hash model.
module tb_sha256_host;

  localparam int TIMEOUT = 255;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] Z55_DIG =
    256'h02779466cdec163811d078815c633f21901413081449002f24aa3e80f0b88ef7;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic       clk = 1'b0;
  logic       rst, msg_valid, msg_last, msg_ready, dig_valid, dig_last, dig_ready;
  logic       busy, err, core_rst_n, core_we, core_irq;
  logic [7:0] msg_data, dig_data, core_data8, core_data;
  logic [6:0] core_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_host dut (
    .i_clk(clk), .i_rst(rst),
    .i_msg_data(msg_data), .i_msg_valid(msg_valid), .i_msg_last(msg_last), .o_msg_ready(msg_ready),
    .o_dig_data(dig_data), .o_dig_valid(dig_valid), .o_dig_last(dig_last), .i_dig_ready(dig_ready),
    .o_busy(busy), .o_err(err), .o_core_rst_n(core_rst_n), .o_core_addr(core_addr),
    .o_core_data8(core_data8), .o_core_we(core_we), .i_core_data(core_data), .i_core_irq(core_irq));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Standard single-block padding with a full 64-bit length field
  function automatic logic [511:0] pad_block(input logic [7:0] msg [$]);
    logic [511:0] blk;
    logic [63:0]  bitlen;
    blk = '0;
    for (int k = 0; k < msg.size(); k++) blk[511 - 8*k -: 8] = msg[k];
    blk[511 - 8*msg.size() -: 8] = 8'h80;
    bitlen = 64'(msg.size()) * 64'd8;
    blk[63:0] = bitlen;
    return blk;
  endfunction

  // Behavioural core: byte memory, start at 65, digest at 101-j, chains unless reset
  logic [7:0]   mem [128];
  logic [255:0] chain_h;
  logic         chain_ok, running;
  logic         irq_en = 1'b1;
  int           run_left, start_cyc;
  logic [14:0]  wlog [$];

  assign core_data = mem[core_addr];

  function automatic logic [511:0] mem_block();
    logic [511:0] blk;
    for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = mem[63 - k];
    return blk;
  endfunction

  always @(posedge clk) begin
    core_irq <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'($urandom);
    end
    if (!core_rst_n) begin
      running  <= 1'b0;
      chain_ok <= 1'b0;
    end else begin
      if (core_we) begin
        mem[core_addr] <= core_data8;
        wlog.push_back({core_addr, core_data8});
        if (core_addr == 7'd65 && core_data8 == 8'h01) begin
          chain_h   <= compress(chain_ok ? chain_h : IV, mem_block());
          chain_ok  <= 1'b1;
          running   <= 1'b1;
          run_left  <= 20;
          start_cyc <= cyc;
        end
      end
      if (running) begin
        if (run_left == 0) begin
          running  <= 1'b0;
          core_irq <= irq_en;
          for (int j = 0; j < 32; j++) mem[101 - j] <= chain_h[255 - 8*j -: 8];
        end else begin
          run_left <= run_left - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
    logic done;
    done = 1'b0;
    msg_data = b; msg_valid = 1'b1; msg_last = last;
    for (int t = 0; t < 100 && !done; t++) begin
      #1 done = msg_ready;
      @(negedge clk);
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic recv_digest(input int mode, input string tag, output logic [255:0] dig);
    int j, t, bad_last, bad_hold;
    logic prev_stall, prev_l;
    logic [7:0] prev_d;
    j = 0; t = 0; bad_last = 0; bad_hold = 0; prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
    dig = '0;
    while (j < 32 && t < 3000) begin
      dig_ready = (mode == 0) ? 1'b1 : (t % 3 == 0);
      #1;
      if (prev_stall && !(dig_valid === 1'b1 && dig_data === prev_d && dig_last === prev_l)) bad_hold++;
      if (dig_valid && dig_ready) begin
        dig[255 - 8*j -: 8] = dig_data;
        if (dig_last !== (j == 31)) bad_last++;
        j++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = dig_valid;
        prev_d = dig_data;
        prev_l = dig_last;
      end
      @(negedge clk);
      t++;
    end
    dig_ready = 1'b0;
    chk({tag, "_nbytes"}, j, 32);
    chk({tag, "_last_flag"}, bad_last, 0);
    chk({tag, "_hold"}, bad_hold, 0);
  endtask

  task automatic log_check(input int base, input logic [7:0] msg [$], input string tag);
    logic [511:0] blk;
    int bad;
    blk = pad_block(msg);
    bad = 0;
    chk({tag, "_nwrites"}, wlog.size() - base, 65);
    for (int k = 0; k < 64; k++)
      if (base + k < wlog.size() && wlog[base + k] !== {7'(63 - k), blk[511 - 8*k -: 8]}) bad++;
    if (base + 64 < wlog.size() && wlog[base + 64] !== {7'd65, 8'h01}) bad++;
    chk({tag, "_writes"}, bad, 0);
  endtask

  task automatic run_msg(input logic [7:0] msg [$], input int mode, input string tag,
                         output logic [255:0] dig);
    int x0, base;
    x0 = cyc;
    base = wlog.size();
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1, {tag, "_hs"});
    msg_valid = 1'b0; msg_last = 1'b0;
    recv_digest(mode, tag, dig);
    #1;
    chk({tag, "_digest"}, dig, compress(IV, pad_block(msg)));
    chk({tag, "_latency"}, start_cyc - x0, 66);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    log_check(base, msg, tag);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]   abc [$];
    logic [7:0]   m [$];
    logic [255:0] d1, d2;
    int           b, n65, n;
    logic         found, saw;
    abc = '{8'h61, 8'h62, 8'h63};
    rst = 1'b1; msg_valid = 1'b0; msg_last = 1'b0; msg_data = '0; dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {msg_ready, dig_data, dig_valid, dig_last, busy, err, core_rst_n,
                             core_addr, core_data8, core_we}, '0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_core_rst_n", core_rst_n, 1'b1);
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);

    b = wlog.size();
    run_msg(abc, 0, "abc1", d1);
    chk("abc1_known", d1, ABC_DIG);
    chk("abc1_len_lo", wlog[b + 63], {7'd0, 8'h18});
    run_msg(abc, 0, "abc2", d2);
    chk("abc_repeat", d2, d1);

    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    b = wlog.size();
    run_msg(m, 0, "z55", d1);
    chk("z55_known", d1, Z55_DIG);
    chk("z55_pad80", wlog[b + 55], {7'd8, 8'h80});
    chk("z55_len_hi", wlog[b + 62], {7'd1, 8'h01});
    chk("z55_len_lo", wlog[b + 63], {7'd0, 8'hB8});

    b = wlog.size();
    for (int i = 0; i < 56; i++) send_byte(8'($urandom), 1'b0, "ovf_hs");
    #1 chk("ovf_err", err, 1'b1);
    chk("ovf_busy_drain", busy, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 2, "drain_hs");
    msg_valid = 1'b0; msg_last = 1'b0;
    #1 chk("drain_idle", busy, 1'b0);
    chk("drain_err_sticky", err, 1'b1);
    n65 = 0;
    for (int i = b; i < wlog.size(); i++) if (wlog[i][14:8] == 7'd65) n65++;
    chk("ovf_no_start", n65, 0);
    @(negedge clk);
    run_msg(abc, 0, "abc_after_ovf", d1);
    chk("abc_after_ovf_known", d1, ABC_DIG);

    for (int r = 0; r < 5; r++) begin
      m.delete();
      n = (r == 0) ? 1 : (r == 1) ? 55 : int'($urandom_range(54, 2));
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      run_msg(m, 0, "rand", d1);
    end

    run_msg(abc, 1, "abc_bp", d1);
    chk("abc_bp_known", d1, ABC_DIG);

    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, "rst_hs");
    msg_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1 chk("midload_reset_outputs", {msg_ready, dig_data, dig_valid, dig_last, busy, err, core_rst_n,
                                     core_addr, core_data8, core_we}, '0);
    b = wlog.size();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("midload_no_writes", wlog.size() - b, 0);
    chk("midload_idle", busy, 1'b0);
    @(negedge clk);
    run_msg(abc, 0, "abc_after_rst", d1);
    chk("abc_after_rst_known", d1, ABC_DIG);

    irq_en = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(abc[i], i == 2, "to_hs");
    msg_valid = 1'b0; msg_last = 1'b0;
    found = 1'b0; saw = 1'b0;
    for (int t = 0; t < 600 && !found; t++) begin
      #1;
      if (dig_valid) saw = 1'b1;
      if (err) found = 1'b1;
      else @(negedge clk);
    end
    chk("timeout_seen", found, 1'b1);
    chk("timeout_cycles", cyc - start_cyc - 1, TIMEOUT);
    chk("timeout_idle", busy, 1'b0);
    chk("timeout_no_digest", saw, 1'b0);
    @(negedge clk);
    irq_en = 1'b1;
    run_msg(abc, 0, "abc_after_to", d1);
    chk("abc_after_to_known", d1, ABC_DIG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
